lcd_nibble_rx: RTL and testbench
================================

# lcd_nibble_rx

- Receive-side endpoint of the 4-bit HD44780-style write bus that `lcd_control` drives (`lcd_e`, `lcd_rs`, `lcd_rw`, `sf_d`).
- Samples each nibble on the falling edge of `lcd_e` and pairs high/low nibbles into bytes.
- Checks strobe width and inter-nibble gap, and presents completed command/data bytes on a valid/ready stream.
- Sits in the display-emulation and self-check path, looped back from the controller's pins or attached to the same pins.

## Interface
Parameters:
- `MIN_E_HIGH`, 10: minimum `lcd_e` high time in clk cycles for a nibble to be accepted.
- `NIBBLE_TIMEOUT`, 200: maximum cycles from high-nibble strobe to low-nibble strobe.
- `CNT_W`, 8: width of the E-high and gap counters. Must satisfy 2^CNT_W > NIBBLE_TIMEOUT.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `lcd_e`  in  1  bus enable strobe, asynchronous to clk.
- `lcd_rs`  in  1  register select: 0 = command, 1 = data.
- `lcd_rw`  in  1  1 = read cycle; read cycles are ignored.
- `sf_d`  in  4  data nibble.
- `rx_data`  out  8  assembled byte.
- `rx_rs`  out  1  RS of the assembled byte.
- `rx_valid`  out  1  the head byte is available.
- `rx_ready`  in  1  consumer accepts the head byte.
- `rx_overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `rx_err_short`  out  1  one-cycle pulse: a strobe was shorter than `MIN_E_HIGH`.
- `rx_err_timeout`  out  1  one-cycle pulse: the low nibble did not arrive within `NIBBLE_TIMEOUT`.
- `rx_err_rs`  out  1  one-cycle pulse: RS differed between the two nibbles of a byte.

## Operation
Input synchronisation and strobe detection:
- `lcd_e`, `lcd_rs`, `lcd_rw` and `sf_d` each pass through a 2-flop synchroniser.
- A falling edge is the condition `e_s2` delayed by one cycle = 1 and `e_s2` = 0.
- The nibble and RS captured are the synchronised values in the falling-edge cycle.
- The E-high counter counts cycles while `e_s2` = 1, saturating at all-ones, and clears while `e_s2` = 0.

Nibble qualification at each falling edge:
- If `rw_s2` = 1, the nibble is discarded silently.
- Otherwise, if the E-high count < `MIN_E_HIGH`, the nibble is discarded and `rx_err_short` pulses. The FSM state is unchanged.
- Otherwise the nibble is valid.

Pairing FSM:
- WAIT_HI:
  - On a valid nibble, latch `hi` and `rs_hi`, clear the gap counter, and go to WAIT_LO.
- WAIT_LO:
  - The gap counter increments every cycle.
  - On a valid nibble with RS = `rs_hi`, push `{hi, nibble}` with `rs_hi` to the FIFO and go to WAIT_HI.
  - On a valid nibble with a different RS, pulse `rx_err_rs`, drop the byte, and go to WAIT_HI.
  - When the gap counter reaches `NIBBLE_TIMEOUT`, pulse `rx_err_timeout` and go to WAIT_HI.
  - If a valid nibble and the timeout occur in the same cycle, the nibble wins and the timeout is not flagged.

Output FIFO (2 entries):
- `rx_valid` = not empty. `rx_data` and `rx_rs` show the head entry and are stable while `rx_valid` = 1 and `rx_ready` = 0.
- A pop occurs when `rx_valid` and `rx_ready` are both 1.
- A push into a full FIFO without a simultaneous pop drops the new byte and sets `rx_overflow`. `rx_overflow` clears only on reset.
- A push and a pop in the same cycle on a full FIFO are both accepted; no overflow is flagged.
- Reset mid-byte discards the latched high nibble and empties the FIFO.

Reset values:
- All outputs are 0: `rx_data` = 8'h00, `rx_rs`, `rx_valid`, `rx_overflow` and all error pulses.
- FSM = WAIT_HI (or INIT8 when `LCD_RX_INIT_EN` is defined), counters cleared, synchronisers cleared.

## Timing
- Latency: the pin `lcd_e` is first sampled low in cycle N. The falling edge is detected in cycle N+2. `rx_valid` rises in cycle N+3 for a low nibble entering an empty FIFO.
- Error pulses are asserted in cycle N+3 and last exactly one cycle.
- Compatibility with `lcd_control` timing: that controller holds E high for 12 cycles and leaves about 50 cycles between strobes, so both default parameters accept it.
- Back-to-back bytes are accepted at any rate down to 2×(`MIN_E_HIGH`+2) cycles per byte.

## Configuration
- Macro: `LCD_RX_INIT_EN`.
- When defined:
  - Reset enters state INIT8, which models the 8-bit power-on phase.
  - Each valid nibble with RS = 0 is pushed as `{nibble, 4'h0}` with `rx_rs` = 0.
  - A nibble of 4'h2 is pushed and then moves the FSM to WAIT_HI.
  - Nibbles with RS = 1 in INIT8 pulse `rx_err_rs` and are dropped.
- When undefined:
  - State INIT8 and its logic are absent.
  - Reset enters WAIT_HI directly.

## Test plan
- Function-set 0x28 with RS = 0 sent as nibbles 2 then 8, each E high 12 cycles, gap 50 cycles, `rx_ready` = 1 -> `rx_valid` pulses one cycle with `rx_data` = 8'h28 and `rx_rs` = 0, 3 cycles after the low strobe falls.
- "FPGA" (0x46, 0x50, 0x47, 0x41) with RS = 1 and `rx_ready` held 0 -> the first two bytes are held in order, `rx_overflow` = 1 after the third byte, and releasing ready yields 0x46 then 0x50.
- 5-cycle E pulse -> `rx_err_short` pulses, no byte, state unchanged; a following legal byte is received correctly.
- High nibble only, then silence for 300 cycles -> `rx_err_timeout` pulses at gap count 200, and the next two nibbles 0x0 then 0x1 yield 8'h01.
- RS = 0 on the high nibble, RS = 1 on the low nibble -> `rx_err_rs` pulses and no byte is produced. Strobes with `lcd_rw` = 1 produce nothing.
- With `LCD_RX_INIT_EN` defined: nibbles 3, 3, 3, 2, then 2, 8 -> bytes 0x30, 0x30, 0x30, 0x20, 0x28. Asserting `reset` low between the 2 and the 8 -> FIFO empty, no 0x28 byte.

Source files
------------

// File: rtl/lcd_nibble_rx.sv
// lcd_nibble_rx: receive endpoint for the 4-bit HD44780-style write bus.
// Samples a nibble on each falling edge of lcd_e, checks strobe width and
// inter-nibble gap, pairs high/low nibbles into bytes, and presents them on a
// valid/ready stream through a 2-entry FIFO.
//
// Optional feature macro: LCD_RX_INIT_EN
//   When defined, reset enters INIT8, which models the 8-bit power-on phase.
//   Each single nibble is delivered as {nibble, 4'h0}; nibble 4'h2 ends it.
//
// Ports:
//   clk            clock, all logic on rising edge
//   reset          synchronous active-low reset
//   lcd_e          bus enable strobe (asynchronous to clk)
//   lcd_rs         register select, 0 = command, 1 = data
//   lcd_rw         1 = read cycle (ignored)
//   sf_d[3:0]      data nibble
//   rx_data[7:0]   head byte of the FIFO
//   rx_rs          RS of the head byte
//   rx_valid       head byte available
//   rx_ready       consumer accepts the head byte
//   rx_overflow    sticky: a byte was dropped on a full FIFO
//   rx_err_short   pulse: strobe shorter than MIN_E_HIGH
//   rx_err_timeout pulse: low nibble missing within NIBBLE_TIMEOUT
//   rx_err_rs      pulse: RS mismatch between the nibbles of a byte
module lcd_nibble_rx #(
  parameter int unsigned MIN_E_HIGH     = 10,
  parameter int unsigned NIBBLE_TIMEOUT = 200,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] sf_d,
  output logic [7:0] rx_data,
  output logic       rx_rs,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overflow,
  output logic       rx_err_short,
  output logic       rx_err_timeout,
  output logic       rx_err_rs
);

`ifdef LCD_RX_INIT_EN
  typedef enum logic [1:0] {
    ST_WAIT_HI = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_INIT8   = 2'd2
  } state_e;
  localparam state_e RESET_STATE = ST_INIT8;
`else
  typedef enum logic [1:0] {
    ST_WAIT_HI = 2'd0,
    ST_WAIT_LO = 2'd1
  } state_e;
  localparam state_e RESET_STATE = ST_WAIT_HI;
`endif

  // Two-flop synchronisers on all bus pins
  logic       e_s1_q, e_s2_q, e_d_q;
  logic       rs_s1_q, rs_s2_q;
  logic       rw_s1_q, rw_s2_q;
  logic [3:0] d_s1_q, d_s2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_s1_q  <= 1'b0;
      e_s2_q  <= 1'b0;
      e_d_q   <= 1'b0;
      rs_s1_q <= 1'b0;
      rs_s2_q <= 1'b0;
      rw_s1_q <= 1'b0;
      rw_s2_q <= 1'b0;
      d_s1_q  <= 4'h0;
      d_s2_q  <= 4'h0;
    end else begin
      e_s1_q  <= lcd_e;
      e_s2_q  <= e_s1_q;
      e_d_q   <= e_s2_q;
      rs_s1_q <= lcd_rs;
      rs_s2_q <= rs_s1_q;
      rw_s1_q <= lcd_rw;
      rw_s2_q <= rw_s1_q;
      d_s1_q  <= sf_d;
      d_s2_q  <= d_s1_q;
    end
  end

  // E-high width counter, saturating; holds the full width in the fall cycle
  logic [CNT_W-1:0] ehi_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ehi_q <= '0;
    end else if (e_s2_q) begin
      if (ehi_q != '1) ehi_q <= ehi_q + CNT_W'(1);
    end else begin
      ehi_q <= '0;
    end
  end

  logic fall_c, nib_ok_c, short_c;
  assign fall_c   = e_d_q & ~e_s2_q;
  assign nib_ok_c = fall_c & ~rw_s2_q & (ehi_q >= CNT_W'(MIN_E_HIGH));
  assign short_c  = fall_c & ~rw_s2_q & (ehi_q <  CNT_W'(MIN_E_HIGH));

  // Pairing FSM state
  state_e           state_q, state_d;
  logic [3:0]       hi_q, hi_d;
  logic             rs_hi_q, rs_hi_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             err_short_q, err_short_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_rs_q, err_rs_d;
  logic             push_c;
  logic [7:0]       push_data_c;
  logic             push_rs_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RESET_STATE;
      hi_q          <= 4'h0;
      rs_hi_q       <= 1'b0;
      gap_q         <= '0;
      err_short_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_rs_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      rs_hi_q       <= rs_hi_d;
      gap_q         <= gap_d;
      err_short_q   <= err_short_d;
      err_timeout_q <= err_timeout_d;
      err_rs_q      <= err_rs_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    rs_hi_d       = rs_hi_q;
    gap_d         = gap_q;
    err_short_d   = short_c;
    err_timeout_d = 1'b0;
    err_rs_d      = 1'b0;
    push_c        = 1'b0;
    push_data_c   = 8'h00;
    push_rs_c     = 1'b0;
    case (state_q)
      ST_WAIT_HI: begin
        if (nib_ok_c) begin
          hi_d    = d_s2_q;
          rs_hi_d = rs_s2_q;
          gap_d   = '0;
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        gap_d = gap_q + CNT_W'(1);
        // A nibble arriving on the timeout cycle takes priority
        if (nib_ok_c) begin
          state_d = ST_WAIT_HI;
          if (rs_s2_q == rs_hi_q) begin
            push_c      = 1'b1;
            push_data_c = {hi_q, d_s2_q};
            push_rs_c   = rs_hi_q;
          end else begin
            err_rs_d = 1'b1;
          end
        end else if (gap_q == CNT_W'(NIBBLE_TIMEOUT)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_WAIT_HI;
        end
      end
`ifdef LCD_RX_INIT_EN
      ST_INIT8: begin
        if (nib_ok_c) begin
          if (rs_s2_q) begin
            err_rs_d = 1'b1;
          end else begin
            push_c      = 1'b1;
            push_data_c = {d_s2_q, 4'h0};
            if (d_s2_q == 4'h2) state_d = ST_WAIT_HI;
          end
        end
      end
`endif
      default: state_d = ST_WAIT_HI;
    endcase
  end

  // Two-entry shift FIFO: entry 0 is always the head
  logic       v0_q, v1_q;
  logic [7:0] data0_q, data1_q;
  logic       rs0_q, rs1_q;
  logic       ovf_q;
  logic       pop_c;

  assign pop_c = v0_q & rx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      data0_q <= 8'h00;
      data1_q <= 8'h00;
      rs0_q   <= 1'b0;
      rs1_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (push_c) begin
      if (!v0_q || (pop_c && !v1_q)) begin
        v0_q    <= 1'b1;
        data0_q <= push_data_c;
        rs0_q   <= push_rs_c;
      end else if (!v1_q) begin
        v1_q    <= 1'b1;
        data1_q <= push_data_c;
        rs1_q   <= push_rs_c;
      end else if (pop_c) begin
        data0_q <= data1_q;
        rs0_q   <= rs1_q;
        data1_q <= push_data_c;
        rs1_q   <= push_rs_c;
      end else begin
        ovf_q <= 1'b1;
      end
    end else if (pop_c) begin
      if (v1_q) begin
        data0_q <= data1_q;
        rs0_q   <= rs1_q;
        v1_q    <= 1'b0;
      end else begin
        v0_q <= 1'b0;
      end
    end
  end

  assign rx_data        = data0_q;
  assign rx_rs          = rs0_q;
  assign rx_valid       = v0_q;
  assign rx_overflow    = ovf_q;
  assign rx_err_short   = err_short_q;
  assign rx_err_timeout = err_timeout_q;
  assign rx_err_rs      = err_rs_q;

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Testbench for lcd_nibble_rx: drives nibble strobes, predicts bytes and error
// pulses with a transaction-level model, and checks them via scoreboard queues.
module tb_lcd_nibble_rx;
  localparam int unsigned MIN_E = 10;
  localparam int unsigned TMO   = 200;

  logic       clk = 1'b0;
  logic       reset, lcd_e, lcd_rs, lcd_rw, rx_ready;
  logic [3:0] sf_d;
  logic [7:0] rx_data;
  logic       rx_rs, rx_valid, rx_overflow;
  logic       rx_err_short, rx_err_timeout, rx_err_rs;

  always #5 clk = ~clk;

  lcd_nibble_rx #(.MIN_E_HIGH(MIN_E), .NIBBLE_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .sf_d(sf_d), .rx_data(rx_data), .rx_rs(rx_rs), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overflow(rx_overflow), .rx_err_short(rx_err_short),
    .rx_err_timeout(rx_err_timeout), .rx_err_rs(rx_err_rs)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: bytes as {rs, data}; errors as 1=short 2=timeout 3=rs
  logic [8:0] exp_q[$];
  int         err_q[$];

  // Transaction-level model state
  bit          pend;
  logic [3:0]  p_nib;
  logic        p_rs;
  int unsigned p_cyc;
  bit          init_mode;
  bit          hold_mode;
  int          held;
  bit          exp_ovf;
  bit          rnd_ready;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, input logic rs);
    if (hold_mode) begin
      if (held >= 2) begin
        exp_ovf = 1'b1;
        return;
      end
      held++;
    end
    exp_q.push_back({rs, b});
  endfunction

  function automatic void model_nib(input logic [3:0] n, input logic rs, input logic rw, input int high);
    if (rw) return;
    if (high < int'(MIN_E)) begin
      err_q.push_back(1);
      return;
    end
    if (init_mode) begin
      if (rs) err_q.push_back(3);
      else begin
        model_byte({n, 4'h0}, 1'b0);
        if (n == 4'h2) init_mode = 1'b0;
      end
      return;
    end
    if (!pend) begin
      pend  = 1'b1;
      p_nib = n;
      p_rs  = rs;
      p_cyc = cyc;
    end else begin
      pend = 1'b0;
      if (rs == p_rs) model_byte({p_nib, n}, rs);
      else err_q.push_back(3);
    end
  endfunction

  // One idle cycle; the model declares a timeout well before the DUT can
  // (stimulus never places a low nibble in the ambiguous window)
  task automatic tick();
    @(posedge clk); #1;
    if (rnd_ready) rx_ready = ($urandom_range(0, 3) != 0);
    if (pend && (cyc - p_cyc) >= 190) begin
      err_q.push_back(2);
      pend = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_nib(input logic [3:0] n, input logic rs, input logic rw, input int high, input int gap);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; sf_d = n; lcd_e = 1'b1;
    repeat (high) @(posedge clk);
    #1 lcd_e = 1'b0;
    model_nib(n, rs, rw, high);
    ticks(gap);
    lcd_rw = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs, input int high, input int gap);
    send_nib(b[7:4], rs, 1'b0, high, gap);
    send_nib(b[3:0], rs, 1'b0, high, gap);
  endtask

  task automatic do_reset(input bit leave_init);
    @(posedge clk); #1;
    reset = 1'b0; lcd_e = 1'b0; lcd_rw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete(); err_q.delete();
    pend = 1'b0; exp_ovf = 1'b0; held = 0; hold_mode = 1'b0;
`ifdef LCD_RX_INIT_EN
    init_mode = 1'b1;
`else
    init_mode = 1'b0;
`endif
    reset = 1'b1;
    @(negedge clk);
    check("rst_valid",    32'(rx_valid), 32'(0));
    check("rst_data",     32'(rx_data), 32'(8'h00));
    check("rst_rs",       32'(rx_rs), 32'(0));
    check("rst_overflow", 32'(rx_overflow), 32'(exp_ovf));
    check("rst_errs",     32'({rx_err_short, rx_err_timeout, rx_err_rs}), 32'(0));
    if (leave_init && init_mode) send_nib(4'h2, 1'b0, 1'b0, 12, 30);
  endtask

  // Monitor: pops expected bytes/errors whenever the DUT presents them
  logic prev_s = 1'b0, prev_t = 1'b0, prev_r = 1'b0;

  task automatic mon_err(input int code, input string name);
    int want;
    if (err_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: got=unexpected pulse want=none (t=%0t)", name, $time);
    end else begin
      want = err_q.pop_front();
      check(name, 32'(code), 32'(want));
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL byte: got=%0h want=none (t=%0t)", {rx_rs, rx_data}, $time);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'({rx_rs, rx_data}), 32'(e));
        end
      end
      if (rx_err_short)   begin mon_err(1, "err_short");   check("short_width", 32'(prev_s), 32'(0)); end
      if (rx_err_timeout) begin mon_err(2, "err_timeout"); check("tmo_width",   32'(prev_t), 32'(0)); end
      if (rx_err_rs)      begin mon_err(3, "err_rs");      check("rs_width",    32'(prev_r), 32'(0)); end
    end
    prev_s = rx_err_short;
    prev_t = rx_err_timeout;
    prev_r = rx_err_rs;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, hd;
    logic       rs, rs2;
    int         lat;
    bit         seen;
    reset = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; sf_d = 4'h0;
    rx_ready = 1'b1; rnd_ready = 1'b0;
    pend = 1'b0; init_mode = 1'b0; hold_mode = 1'b0; held = 0; exp_ovf = 1'b0;

`ifdef LCD_RX_INIT_EN
    // Power-on sequence in INIT8, RS=1 rejected, then a normal 0x28
    do_reset(1'b0);
    send_nib(4'h3, 1'b0, 1'b0, 12, 50);
    send_nib(4'h5, 1'b1, 1'b0, 12, 50);
    send_nib(4'h3, 1'b0, 1'b0, 12, 50);
    send_nib(4'h3, 1'b0, 1'b0, 12, 50);
    send_nib(4'h2, 1'b0, 1'b0, 12, 50);
    send_byte(8'h28, 1'b0, 12, 50);
    ticks(20);
    // Reset between the 2 and the 8: no 0x28
    do_reset(1'b0);
    send_nib(4'h3, 1'b0, 1'b0, 12, 50);
    send_nib(4'h2, 1'b0, 1'b0, 12, 50);
    send_nib(4'h2, 1'b0, 1'b0, 12, 50);
    do_reset(1'b0);
    send_nib(4'h8, 1'b0, 1'b0, 12, 50);
    send_nib(4'h2, 1'b0, 1'b0, 12, 50);
    ticks(20);
    check("init_drained", 32'(exp_q.size()), 32'(0));
`endif

    do_reset(1'b1);
    ticks(20);

    // Function set 0x28 with latency measurement on the low nibble
    send_nib(4'h2, 1'b0, 1'b0, 12, 50);
    send_nib(4'h8, 1'b0, 1'b0, 12, 0);
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (rx_valid) begin seen = 1'b1; lat = i; end
    end
    check("latency", 32'(lat), 32'(4));
    @(negedge clk);
    check("valid_one_cycle", 32'(rx_valid), 32'(0));
    ticks(40);

    // "FPGA" with ready low: two held, overflow on the rest
    rx_ready = 1'b0; hold_mode = 1'b1; held = 0;
    send_byte(8'h46, 1'b1, 12, 50);
    send_byte(8'h50, 1'b1, 12, 50);
    send_byte(8'h47, 1'b1, 12, 50);
    send_byte(8'h41, 1'b1, 12, 50);
    ticks(10);
    check("ovf_set", 32'(rx_overflow), 32'(exp_ovf));
    check("ovf_valid", 32'(rx_valid), 32'(1));
    hd = exp_q[0][7:0];
    check("ovf_head", 32'(rx_data), 32'(hd));
    hold_mode = 1'b0;
    rx_ready = 1'b1;
    ticks(10);
    check("ovf_drained", 32'(exp_q.size()), 32'(0));
    check("ovf_sticky", 32'(rx_overflow), 32'(exp_ovf));
    do_reset(1'b1);
    ticks(20);

    // Short strobes, boundary widths, short strobe inside a byte
    send_nib(4'hA, 1'b1, 1'b0, 5, 40);
    send_byte(8'hA5, 1'b1, 12, 40);
    send_nib(4'h6, 1'b0, 1'b0, 9, 40);
    send_byte(8'h6B, 1'b0, 10, 40);
    send_nib(4'h3, 1'b0, 1'b0, 12, 30);
    send_nib(4'hF, 1'b1, 1'b0, 4, 30);
    send_nib(4'hC, 1'b0, 1'b0, 12, 30);

    // Timeout after a lone high nibble, then 0x01
    send_nib(4'h7, 1'b0, 1'b0, 12, 300);
    send_byte(8'h01, 1'b0, 12, 50);

    // RS mismatch; read cycles ignored
    send_nib(4'h4, 1'b0, 1'b0, 12, 50);
    send_nib(4'h1, 1'b1, 1'b0, 12, 50);
    send_nib(4'h5, 1'b0, 1'b1, 12, 30);
    send_nib(4'h6, 1'b0, 1'b1, 12, 30);
    send_byte(8'h99, 1'b1, 12, 40);
    ticks(20);

    // Reset drops a latched high nibble and a queued byte
    send_nib(4'h5, 1'b0, 1'b0, 12, 20);
    rx_ready = 1'b0;
    do_reset(1'b1);
    rx_ready = 1'b1;
    send_byte(8'h3C, 1'b0, 12, 30);
    rx_ready = 1'b0;
    send_byte(8'h77, 1'b1, 12, 20);
    do_reset(1'b1);
    rx_ready = 1'b1;
    ticks(20);

    // Randomised traffic with junk strobes, RS flips and occasional timeouts
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      b   = 8'($urandom);
      rs  = 1'($urandom);
      rs2 = ($urandom_range(0, 7) == 0) ? ~rs : rs;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) send_nib(4'($urandom), 1'($urandom), 1'b1, $urandom_range(5, 30), $urandom_range(10, 40));
        else send_nib(4'($urandom), 1'($urandom), 1'b0, $urandom_range(1, 9), $urandom_range(10, 40));
      end
      if ($urandom_range(0, 7) == 0)
        send_nib(b[7:4], rs, 1'b0, $urandom_range(10, 30), $urandom_range(260, 320));
      else
        send_nib(b[7:4], rs, 1'b0, $urandom_range(10, 30), $urandom_range(10, 60));
      if ($urandom_range(0, 5) == 0)
        send_nib(4'($urandom), 1'($urandom), 1'b0, $urandom_range(1, 9), $urandom_range(10, 40));
      send_nib(b[3:0], rs2, 1'b0, $urandom_range(10, 30), $urandom_range(10, 60));
    end
    rnd_ready = 1'b0;
    rx_ready = 1'b1;
    ticks(260);
    check("final_bytes_drained", 32'(exp_q.size()), 32'(0));
    check("final_errs_drained", 32'(err_q.size()), 32'(0));
    check("final_no_overflow", 32'(rx_overflow), 32'(exp_ovf));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
